// File: rtl/sign_compressor.sv
// Strips redundant sign bits from a two's-complement word, one bit per cycle,
// and returns the minimal length, the left-aligned value and the truncated value.
module sign_compressor #(
  parameter int unsigned W = 8,
  localparam int unsigned LW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [LW-1:0] out_len,
  output logic [W-1:0]  out_norm,
  output logic [W-1:0]  out_trunc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          accept;
  logic          shift;
  logic          finish;
  logic [W-1:0]  orig;
  logic [W-1:0]  work;
  logic [LW-1:0] len;
  logic [W-1:0]  mask_c;

  // Next-state and datapath control
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    shift     = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if ((len > LW'(1)) && (work[W-1] == work[W-2])) begin
          shift = 1'b1;
        end else begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Keep-mask for the low len bits of the original word
  always_comb begin
    mask_c = '0;
    for (int i = 0; i < int'(W); i++) begin
      mask_c[i] = (LW'(i) < len);
    end
  end

  // State register with handshake flags decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
    end
  end

  // Working registers; results are captured once so they hold between words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      orig      <= '0;
      work      <= '0;
      len       <= '0;
      out_len   <= LW'(W);
      out_norm  <= '0;
      out_trunc <= '0;
    end else begin
      if (accept) begin
        orig <= in_data;
        work <= in_data;
        len  <= LW'(W);
      end
      if (shift) begin
        work <= {work[W-2:0], 1'b0};
        len  <= len - LW'(1);
      end
      if (finish) begin
        out_len   <= len;
        out_norm  <= work;
        out_trunc <= orig & mask_c;
      end
    end
  end

endmodule

// File: tb/tb_sign_compressor.sv
// Randomized and directed bench for sign_compressor (W=8) against a
// sign-extension reference model.
module tb_sign_compressor;

  localparam int unsigned W  = 8;
  localparam int unsigned LW = $clog2(W + 1);

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] out_len;
  logic [W-1:0]  out_norm;
  logic [W-1:0]  out_trunc;

  int errors;
  int checks;

  sign_compressor #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_len   (out_len),
    .out_norm  (out_norm),
    .out_trunc (out_trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sign-extend the low n bits of t to the full width
  function automatic logic [7:0] sext(input logic [7:0] t, input int n);
    logic [7:0] m;
    m = 8'((1 << n) - 1);
    return t[n-1] ? (t | ~m) : (t & m);
  endfunction

  // Smallest n whose sign extension reproduces x
  function automatic int ref_len(input logic [7:0] x);
    for (int n = 1; n <= 8; n++) begin
      if (sext(x & 8'((1 << n) - 1), n) == x) return n;
    end
    return 8;
  endfunction

  task automatic send(input logic [7:0] x);
    @(negedge clk);
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = x;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // Wait for the result (called at accept edge + #1), check it, then hand it off
  task automatic collect(input logic [7:0] x, input int e_len, input logic [7:0] e_norm,
                         input logic [7:0] e_trunc, input int e_lat, input int hold,
                         input bit noise);
    int lat;
    int n;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      if (noise) begin
        in_valid = 1'($urandom);
        in_data  = 8'($urandom);
      end
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    check("latency", 32'(lat), 32'(e_lat));
    check("out_len", 32'(out_len), 32'(e_len));
    check("out_norm", 32'(out_norm), 32'(e_norm));
    check("out_trunc", 32'(out_trunc), 32'(e_trunc));
    check("in_ready_busy", 32'(in_ready), 32'd0);
    n = (out_len >= 1 && out_len <= 8) ? int'(out_len) : 1;
    check("roundtrip", 32'(sext(out_trunc, n)), 32'(x));
    for (int h = 0; h < hold; h++) begin
      if (noise) begin
        in_valid = 1'($urandom);
        in_data  = 8'($urandom);
      end
      @(posedge clk);
      #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_norm", 32'(out_norm), 32'(e_norm));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("valid_after_handshake", 32'(out_valid), 32'd0);
    check("ready_after_handshake", 32'(in_ready), 32'd1);
  endtask

  logic [7:0] dir_in    [6] = '{8'h05, 8'hFB, 8'h00, 8'hFF, 8'h80, 8'h7F};
  int         dir_len   [6] = '{4, 4, 1, 1, 8, 8};
  logic [7:0] dir_norm  [6] = '{8'h50, 8'hB0, 8'h00, 8'h80, 8'h80, 8'h7F};
  logic [7:0] dir_trunc [6] = '{8'h05, 8'h0B, 8'h00, 8'h01, 8'h80, 8'h7F};
  int         dir_lat   [6] = '{5, 5, 8, 8, 1, 1};

  initial begin
    logic [7:0] order [256];
    logic [7:0] x;
    logic [7:0] tmp;
    int         n;
    int         j;

    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    #13;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_len", 32'(out_len), 32'd8);
    check("reset_out_norm", 32'(out_norm), 32'd0);
    check("reset_out_trunc", 32'(out_trunc), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      send(dir_in[i]);
      collect(dir_in[i], dir_len[i], dir_norm[i], dir_trunc[i], dir_lat[i], 0, 1'b0);
    end

    // Backpressure: result held, a waiting word only taken after the handoff
    send(8'h05);
    collect_wait: for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) break;
    end
    check("bp_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'hFB;
    for (int h = 0; h < 10; h++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_ready", 32'(in_ready), 32'd0);
      check("bp_hold_len", 32'(out_len), 32'd4);
      check("bp_hold_norm", 32'(out_norm), 32'h50);
      check("bp_hold_trunc", 32'(out_trunc), 32'h05);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_no_same_cycle_accept", 32'(in_ready), 32'd1);
    check("bp_valid_drop", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_second_accepted", 32'(in_ready), 32'd0);
    collect(8'hFB, 4, 8'hB0, 8'h0B, 5, 0, 1'b0);

    // Leave a non-reset result behind, then reset mid-shift
    send(8'h7F);
    collect(8'h7F, 8, 8'h7F, 8'h7F, 1, 0, 1'b0);
    send(8'h01);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_len", 32'(out_len), 32'd8);
    check("midrst_out_norm", 32'(out_norm), 32'd0);
    check("midrst_out_trunc", 32'(out_trunc), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      check("midrst_no_result", 32'(out_valid), 32'd0);
    end
    send(8'h03);
    collect(8'h03, 3, 8'h60, 8'h03, 6, 0, 1'b0);

    // Every input once, shuffled, with random hold and ignored in_valid noise
    for (int i = 0; i < 256; i++) order[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      j        = int'($urandom_range(i, 0));
      tmp      = order[i];
      order[i] = order[j];
      order[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      x = order[i];
      n = ref_len(x);
      send(x);
      collect(x, n, 8'(int'(x) << (8 - n)), x & 8'((1 << n) - 1), 9 - n,
              int'($urandom_range(2, 0)), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
